// File: rtl/mem_dumper_pkg.sv
// mem_dumper_pkg: shared state encoding and default window for the data-memory dumper
package dump_pkg;
  typedef enum logic [1:0] {IDLE, READ, SEND, FIN} dump_state_t;
  localparam int DUMP_BASE = 0;
  localparam int DUMP_COUNT = 64;
  localparam int CNT_W = 9;
endpackage

// File: rtl/mem_dumper.sv
// mem_dumper: streams a window of data memory over valid/ready with an XOR checksum once the core is done
module mem_dumper
  import dump_pkg::*;
#(
  parameter int BASE = DUMP_BASE,
  parameter int COUNT = DUMP_COUNT,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          done_in,
  input  logic [7:0]    mem_dat,
  output logic [AW-1:0] mem_addr,
  output logic          host_sel,
  output logic [7:0]    dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          busy,
  output logic          finished,
  output logic [7:0]    xsum
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);
  dump_state_t      state_q, state_d;
  logic             done_q;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       dout_q, dout_d, xsum_q, xsum_d;
  logic             start;
  assign start      = done_in & ~done_q;
  assign mem_addr   = ptr_q;
  assign dout       = dout_q;
  assign xsum       = xsum_q;
  assign host_sel   = (state_q == READ) || (state_q == SEND);
  assign busy       = host_sel;
  assign dout_valid = state_q == SEND;
  assign finished   = state_q == FIN;
  // next-state: arm on a done rise, one read then a handshake per byte, park in FIN until done drops
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    xsum_d  = xsum_q;
    case (state_q)
      IDLE: if (start) begin
        ptr_d   = AW'(BASE);
        cnt_d   = '0;
        xsum_d  = '0;
        state_d = READ;
      end
      READ: begin
        dout_d  = mem_dat;
        state_d = SEND;
      end
      SEND: if (dout_ready) begin
        xsum_d  = xsum_q ^ dout_q;
        cnt_d   = cnt_q + 1'b1;
        ptr_d   = (cnt_q == LAST) ? ptr_q : ptr_q + 1'b1;
        state_d = (cnt_q == LAST) ? FIN : READ;
      end
      FIN: state_d = done_in ? FIN : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; reset aborts any dump in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      xsum_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_in;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      xsum_q  <= xsum_d;
    end
  end
endmodule

// File: tb/tb_mem_dumper.sv
// tb_mem_dumper: table-driven dump runs with a byte/address scoreboard plus reset and restart sequences
module tb_mem_dumper;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [7:0] mem [256];
  logic done [3];
  logic rdy [3];
  logic hs [3];
  logic dv [3];
  logic bsy [3];
  logic fin [3];
  logic [7:0] addr [3];
  logic [7:0] md [3];
  logic [7:0] dout [3];
  logic [7:0] xs [3];
  assign md[0] = mem[addr[0]];
  assign md[1] = mem[addr[1]];
  assign md[2] = mem[addr[2]];
  mem_dumper #(.BASE(0), .COUNT(4), .AW(8)) u0 (
    .clk(clk), .reset(rst), .done_in(done[0]), .mem_dat(md[0]), .mem_addr(addr[0]),
    .host_sel(hs[0]), .dout(dout[0]), .dout_valid(dv[0]), .dout_ready(rdy[0]),
    .busy(bsy[0]), .finished(fin[0]), .xsum(xs[0]));
  mem_dumper #(.BASE(254), .COUNT(4), .AW(8)) u1 (
    .clk(clk), .reset(rst), .done_in(done[1]), .mem_dat(md[1]), .mem_addr(addr[1]),
    .host_sel(hs[1]), .dout(dout[1]), .dout_valid(dv[1]), .dout_ready(rdy[1]),
    .busy(bsy[1]), .finished(fin[1]), .xsum(xs[1]));
  mem_dumper #(.BASE(0), .COUNT(256), .AW(8)) u2 (
    .clk(clk), .reset(rst), .done_in(done[2]), .mem_dat(md[2]), .mem_addr(addr[2]),
    .host_sel(hs[2]), .dout(dout[2]), .dout_valid(dv[2]), .dout_ready(rdy[2]),
    .busy(bsy[2]), .finished(fin[2]), .xsum(xs[2]));

  typedef struct {
    int k;
    int base;
    int count;
    int stall;
    int drop;
    logic [31:0] bytes;
    int exp_x;
    int exp_n;
  } vec_t;
  vec_t vecs [6];
  int nchk = 0;
  int nerr = 0;
  logic [7:0] q [$];
  int aq [$];

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  task automatic fill(input vec_t v);
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    if (v.count == 4)
      for (int i = 0; i < 4; i++) mem[(v.base + i) % 256] = v.bytes[8*i +: 8];
  endtask

  task automatic run_dump(input vec_t v);
    int n, idx, first, stall_left, k;
    bit holding;
    logic [7:0] held;
    k = v.k;
    n = 0; idx = 0; first = 0; holding = 0; held = '0;
    stall_left = v.stall;
    fill(v);
    q.delete();
    aq.delete();
    for (int i = 0; i < v.count; i++) begin
      q.push_back(mem[(v.base + i) % 256]);
      aq.push_back((v.base + i) % 256);
    end
    @(negedge clk);
    rdy[k] = 1'b1;
    done[k] = 1'b1;
    @(posedge clk);
    while (n < 2000) begin
      @(negedge clk);
      n++;
      if (v.drop == n) done[k] = 1'b0;
      if (holding) begin
        chk("hold_valid", int'(dv[k]), 1);
        chk("hold_dout", int'(dout[k]), int'(held));
      end
      holding = 0;
      if (bsy[k] && !dv[k]) begin
        if (aq.size() == 0) chk("extra_read", 1, 0);
        else chk("read_addr", int'(addr[k]), aq.pop_front());
      end
      if (dv[k]) begin
        if (first == 0) begin
          first = n;
          chk("first_valid_cycle", n, 2);
        end
        rdy[k] = !(idx == 1 && stall_left > 0);
        if (!rdy[k]) begin
          stall_left--;
          holding = 1;
          held = dout[k];
        end else if (q.size() == 0) chk("extra_byte", 1, 0);
        else begin
          chk("byte", int'(dout[k]), int'(q.pop_front()));
          idx++;
        end
      end
      if (fin[k]) break;
    end
    chk("cycles_to_fin", n, v.exp_n);
    chk("xsum", int'(xs[k]), v.exp_x);
    chk("bytes_accepted", idx, v.count);
    chk("host_sel_in_fin", int'(hs[k]), 0);
    if (v.drop == 0) begin
      @(negedge clk);
      chk("fin_held_while_done", int'(fin[k]), 1);
      done[k] = 1'b0;
    end
    @(negedge clk);
    chk("fin_exit", int'(fin[k]), 0);
    chk("idle_after_fin", int'(bsy[k]), 0);
    chk("xsum_kept_idle", int'(xs[k]), v.exp_x);
  endtask

  initial begin
    int seen;
    for (int i = 0; i < 3; i++) begin
      done[i] = 1'b0;
      rdy[i] = 1'b1;
    end
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    vecs[0] = '{0, 0, 4, 0, 0, 32'h44332211, 8'h44, 9};
    vecs[1] = '{0, 0, 4, 3, 0, 32'h44332211, 8'h44, 12};
    vecs[2] = '{1, 254, 4, 0, 0, 32'h80040201, 8'h87, 9};
    vecs[3] = '{1, 254, 4, 1, 0, 32'hF00F5AA5, 8'h00, 10};
    vecs[4] = '{2, 0, 256, 0, 0, 32'h0, 8'h00, 513};
    vecs[5] = '{0, 0, 4, 0, 3, 32'h44332211, 8'h44, 9};
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_host_sel", int'(hs[i]), 0);
      chk("rst_valid", int'(dv[i]), 0);
      chk("rst_busy", int'(bsy[i]), 0);
      chk("rst_finished", int'(fin[i]), 0);
      chk("rst_xsum", int'(xs[i]), 0);
      chk("rst_dout", int'(dout[i]), 0);
      chk("rst_addr", int'(addr[i]), 0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_start", int'(bsy[0]), 0);
    for (int i = 0; i < 6; i++) run_dump(vecs[i]);
    fill(vecs[0]);
    @(negedge clk);
    done[0] = 1'b1;
    rdy[0] = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && seen < 2; i++) begin
      @(negedge clk);
      if (dv[0]) seen++;
    end
    chk("second_byte_reached", seen, 2);
    chk("second_byte_value", int'(dout[0]), 8'h22);
    rst = 1'b1;
    #1;
    chk("abort_valid", int'(dv[0]), 0);
    chk("abort_host_sel", int'(hs[0]), 0);
    chk("abort_busy", int'(bsy[0]), 0);
    chk("abort_xsum", int'(xs[0]), 0);
    @(negedge clk);
    chk("no_start_in_reset", int'(bsy[0]), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("restart_after_reset", int'(bsy[0]), 1);
    chk("restart_addr", int'(addr[0]), 0);
    @(negedge clk);
    chk("restart_first_byte", int'(dout[0]), 8'h11);
    rst = 1'b1;
    done[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
